// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and width helpers for the UART transmit FIFO.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} tx_state_t;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read (distributed RAM).
module fifo_ram
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ptr_bits(DEPTH)-1:0] waddr,
    input  logic [DATA_BITS-1:0]       wdata,
    input  logic [ptr_bits(DEPTH)-1:0] raddr,
    output logic [DATA_BITS-1:0]       rdata
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO draining into uart_lite over the tx_rdy/tx_vld handshake.
//   state | meaning
//   IDLE  | waiting for a queued byte and tx_rdy; pops on exit
//   ISSUE | tx_vld strobe cycle
//   BUSY  | waiting for uart_lite to drop tx_rdy, bounded by BUSY_TIMEOUT
//   DONE  | frame in progress, waiting for tx_rdy to return
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       wr_vld,
    input  logic [DATA_BITS-1:0]       wr_data,
    output logic                       wr_rdy,
    input  logic                       tx_rdy,
    output logic                       tx_vld,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic [cnt_bits(DEPTH)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PW = ptr_bits(DEPTH);
    localparam int CW = cnt_bits(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 push, pop, ovf_evt;

    tx_state_t            state, state_nxt;
    logic [TW-1:0]        tmo_cnt, tmo_nxt;
    logic                 tx_vld_nxt;
    logic [DATA_BITS-1:0] tx_data_nxt;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign wr_rdy  = !full;
    assign pop     = (state == IDLE) && !empty && tx_rdy;
    // full is the pre-edge value, so a same-cycle pop never frees a slot for this push
    assign push    = wr_vld && !full;
    assign ovf_evt = wr_vld && full;

    fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (ovf_evt)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            tmo_cnt <= '0;
            tx_vld  <= 1'b0;
            tx_data <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            tx_vld  <= tx_vld_nxt;
            tx_data <= tx_data_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_nxt     = tmo_cnt;
        tx_vld_nxt  = 1'b0;
        tx_data_nxt = tx_data;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt   = ISSUE;
                    tx_vld_nxt  = 1'b1;
                    tx_data_nxt = rd_data;
                end
            end
            ISSUE: begin
                state_nxt = BUSY;
                tmo_nxt   = '0;
            end
            BUSY: begin
                if (!tx_rdy)                                state_nxt = DONE;
                else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) state_nxt = IDLE;
                else                                        tmo_nxt   = tmo_cnt + TW'(1);
            end
            DONE: begin
                if (tx_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
